mult_sched: RTL and testbench

Two-port round-robin scheduler for the 16-lane ternary element-wise multiplier in the decoder datapath. Each requester offers a pair of packed ternary vectors. The block arbitrates, registers the operands, and drives one shared `multiplier` instance. It returns the registered product vector plus its signed lane sum, tagged with the requester id, over a valid/ready output port that supports back-pressure.

---
 rtl/mult_sched_if.sv | 36 +++
 rtl/mult_sched.sv | 116 +++++++++++
 tb/tb_mult_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - request/result bus of the two-port ternary multiplier scheduler
interface mult_sched_if #(
   parameter int LANES = 16,
   parameter int SUMW  = 6
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [2*LANES-1:0]   req0_a;
   logic [2*LANES-1:0]   req0_b;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [2*LANES-1:0]   req1_a;
   logic [2*LANES-1:0]   req1_b;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_id;
   logic [2*LANES-1:0]   out_c;
   logic [SUMW-1:0]      out_sum;
   logic                 busy;

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output out_ready,
      input  req0_ready, req1_ready,
      input  out_valid, out_id, out_c, out_sum, busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  out_ready,
      output req0_ready, req1_ready,
      output out_valid, out_id, out_c, out_sum, busy
   );
endinterface

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin two-port scheduler feeding one ternary lane multiplier
module multiplier #(
   parameter int LANES = 16
) (
   input  logic [2*LANES-1:0] a,
   input  logic [2*LANES-1:0] b,
   output logic [2*LANES-1:0] c
);
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      // sign is masked by magnitude so zero lanes always come out as 00
      assign c[2*i]   = a[2*i] & b[2*i];
      assign c[2*i+1] = (a[2*i+1] ^ b[2*i+1]) & a[2*i] & b[2*i];
   end
endmodule

module mult_sched #(
   parameter int LANES = 16,
   parameter int SUMW  = 6
) (
   input  logic      clk,
   input  logic      reset,
   mult_sched_if.slave bus
);
   logic               pri;
   logic               s1_valid;
   logic               s1_id;
   logic [2*LANES-1:0] s1_a;
   logic [2*LANES-1:0] s1_b;
   logic               out_valid_q;
   logic               out_id_q;
   logic [2*LANES-1:0] out_c_q;
   logic [SUMW-1:0]    out_sum_q;

   logic               adv1;
   logic               adv2;
   logic               ready0;
   logic               ready1;
   logic               fire0;
   logic               fire1;
   logic [2*LANES-1:0] prod;
   logic [SUMW-1:0]    lane_sum;

   assign adv2   = !out_valid_q || bus.out_ready;
   assign adv1   = !s1_valid || adv2;
   // readies depend only on the other port's valid, never on their own
   assign ready0 = adv1 && (!bus.req1_valid || !pri);
   assign ready1 = adv1 && (!bus.req0_valid || pri);
   assign fire0  = bus.req0_valid && ready0;
   assign fire1  = bus.req1_valid && ready1;

   multiplier #(.LANES(LANES)) u_mult (
      .a (s1_a),
      .b (s1_b),
      .c (prod)
   );

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         if (prod[2*i]) begin
            if (prod[2*i+1]) lane_sum = lane_sum - SUMW'(1);
            else             lane_sum = lane_sum + SUMW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pri      <= 1'b0;
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         if (fire0)      pri <= 1'b1;
         else if (fire1) pri <= 1'b0;
         if (adv1) begin
            s1_valid <= fire0 || fire1;
            if (fire0) begin
               s1_a  <= bus.req0_a;
               s1_b  <= bus.req0_b;
               s1_id <= 1'b0;
            end else if (fire1) begin
               s1_a  <= bus.req1_a;
               s1_b  <= bus.req1_b;
               s1_id <= 1'b1;
            end
         end
      end
   end

   // payload only moves with a valid S1 entry so idle cycles keep the last result steady
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_id_q    <= 1'b0;
         out_c_q     <= '0;
         out_sum_q   <= '0;
      end else if (adv2) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_id_q  <= s1_id;
            out_c_q   <= prod;
            out_sum_q <= lane_sum;
         end
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_id     = out_id_q;
   assign bus.out_c      = out_c_q;
   assign bus.out_sum    = out_sum_q;
   assign bus.busy       = s1_valid || out_valid_q;
endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - directed bench for mult_sched
module tb_mult_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mult_sched_if #(.LANES(16), .SUMW(6)) bus ();

   mult_sched dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_a     = '0;
      bus.req0_b     = '0;
      bus.req1_valid = 1'b0;
      bus.req1_a     = '0;
      bus.req1_b     = '0;
      bus.out_ready  = 1'b1;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
      vectors++; if (bus.out_c !== 32'h0) begin miscompares++; $display("FAIL reset_out_c: got %0h expected 0", bus.out_c); end
      vectors++; if (bus.out_sum !== 6'h0) begin miscompares++; $display("FAIL reset_out_sum: got %0h expected 0", bus.out_sum); end
      vectors++; if (bus.out_id !== 1'b0) begin miscompares++; $display("FAIL reset_out_id: got %0b expected 0", bus.out_id); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req0_ready: got %0b expected 1", bus.req0_ready); end
      vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req1_ready: got %0b expected 1", bus.req1_ready); end
   endtask

   task automatic test_single_ops();
      logic [31:0] ta [3] = '{32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0005};
      logic [31:0] tb [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
      logic [31:0] tc [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0007};
      logic [5:0]  ts [3] = '{6'b110000, 6'b000000, 6'b000000};
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1;
         bus.req0_valid = 1'b1;
         bus.req0_a     = ta[r];
         bus.req0_b     = tb[r];
         #1;
         vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_accept[%0d]: got %0b expected 1", r, bus.req0_ready); end
         @(posedge clk); #1;
         bus.req0_valid = 1'b0;
         vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_s1[%0d]: got valid %0b busy %0b expected 0 1", r, bus.out_valid, bus.busy); end
         @(posedge clk); #1;
         vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid[%0d]: got %0b expected 1", r, bus.out_valid); end
         vectors++; if (bus.out_c !== tc[r]) begin miscompares++; $display("FAIL single_out_c[%0d]: got %0h expected %0h", r, bus.out_c, tc[r]); end
         vectors++; if (bus.out_sum !== ts[r]) begin miscompares++; $display("FAIL single_out_sum[%0d]: got %0b expected %0b", r, bus.out_sum, ts[r]); end
         vectors++; if (bus.out_id !== 1'b0) begin miscompares++; $display("FAIL single_out_id[%0d]: got %0b expected 0", r, bus.out_id); end
         @(posedge clk); #1;
         vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_drain[%0d]: got valid %0b busy %0b expected 0 0", r, bus.out_valid, bus.busy); end
      end
   endtask

   task automatic test_contention();
      logic       exp_id;
      logic [31:0] exp_c;
      pulse_reset();
      bus.req0_a     = 32'h5555_5555;
      bus.req0_b     = 32'hFFFF_FFFF;
      bus.req1_a     = 32'h5555_5555;
      bus.req1_b     = 32'h5555_5555;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.out_ready  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         vectors++; if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin miscompares++; $display("FAIL contention_grant[%0d]: got %0b%0b expected port %0d", k, bus.req0_ready, bus.req1_ready, k % 2); end
         @(posedge clk); #1;
         if (k >= 1) begin
            exp_id = ((k - 1) % 2 == 1);
            exp_c  = exp_id ? 32'h5555_5555 : 32'hFFFF_FFFF;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_c !== exp_c) begin miscompares++; $display("FAIL contention_out[%0d]: got v%0b id%0b c%0h expected v1 id%0b c%0h", k, bus.out_valid, bus.out_id, bus.out_c, exp_id, exp_c); end
         end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_id !== 1'b1 || bus.out_c !== 32'h5555_5555) begin miscompares++; $display("FAIL contention_last: got v%0b id%0b c%0h expected v1 id1 c55555555", bus.out_valid, bus.out_id, bus.out_c); end
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL contention_drain: got %0b expected 0", bus.out_valid); end
   endtask

   task automatic test_back_pressure();
      logic [31:0] ta [6] = '{32'h5555_5555, 32'hAAAA_AAAA, 32'h5, 32'h5555_5555, 32'h1, 32'h3};
      logic [31:0] tb [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'h5555_5555, 32'h1, 32'h1};
      logic [31:0] tc [6] = '{32'hFFFF_FFFF, 32'h0, 32'h7, 32'h5555_5555, 32'h1, 32'h3};
      logic [5:0]  ts [6] = '{6'b110000, 6'b000000, 6'b000000, 6'b010000, 6'b000001, 6'b111111};
      int src = 0;
      int snk = 0;
      pulse_reset();
      for (int cyc = 0; cyc < 40 && snk < 6; cyc++) begin
         bus.req0_valid = (src < 6);
         if (src < 6) begin
            bus.req0_a = ta[src];
            bus.req0_b = tb[src];
         end
         bus.out_ready = !(cyc >= 3 && cyc < 8);
         #1;
         if (cyc >= 3 && cyc < 8) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_c !== tc[snk] || bus.out_sum !== ts[snk] || bus.out_id !== 1'b0) begin miscompares++; $display("FAIL stall_hold[%0d]: got v%0b c%0h s%0b id%0b expected v1 c%0h s%0b id0", cyc, bus.out_valid, bus.out_c, bus.out_sum, bus.out_id, tc[snk], ts[snk]); end
            vectors++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d]: got %0b%0b expected 00", cyc, bus.req0_ready, bus.req1_ready); end
         end
         if (bus.req0_valid && bus.req0_ready) src++;
         if (bus.out_valid && bus.out_ready) begin
            vectors++; if (bus.out_c !== tc[snk] || bus.out_sum !== ts[snk] || bus.out_id !== 1'b0) begin miscompares++; $display("FAIL bp_result[%0d]: got c%0h s%0b id%0b expected c%0h s%0b id0", snk, bus.out_c, bus.out_sum, bus.out_id, tc[snk], ts[snk]); end
            snk++;
         end
         @(posedge clk); #1;
      end
      vectors++; if (snk != 6) begin miscompares++; $display("FAIL bp_delivered: got %0d expected 6", snk); end
      bus.req0_valid = 1'b0;
      bus.out_ready  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup[%0d]: got %0b expected 0", k, bus.out_valid); end
      end
   endtask

   task automatic test_reset_midflight();
      pulse_reset();
      bus.req0_a     = 32'h5555_5555;
      bus.req0_b     = 32'hFFFF_FFFF;
      bus.req1_a     = 32'hAAAA_AAAA;
      bus.req1_b     = 32'hFFFF_FFFF;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.out_ready  = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_full: got v%0b busy%0b expected 1 1", bus.out_valid, bus.busy); end
      vectors++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL mid_full_ready: got %0b%0b expected 00", bus.req0_ready, bus.req1_ready); end
      rst = 1'b1;
      #1;
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_async_clear: got v%0b busy%0b expected 0 0", bus.out_valid, bus.busy); end
      bus.req0_a = 32'h1;
      bus.req0_b = 32'h1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL mid_tie: got %0b%0b expected 10", bus.req0_ready, bus.req1_ready); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_s1: got v%0b busy%0b expected 0 1", bus.out_valid, bus.busy); end
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_c !== 32'h1 || bus.out_sum !== 6'b000001 || bus.out_id !== 1'b0) begin miscompares++; $display("FAIL mid_fresh: got v%0b c%0h s%0b id%0b expected v1 c1 s000001 id0", bus.out_valid, bus.out_c, bus.out_sum, bus.out_id); end
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_no_stale: got v%0b busy%0b expected 0 0", bus.out_valid, bus.busy); end
   endtask

   initial begin
      test_reset();
      test_single_ops();
      test_contention();
      test_back_pressure();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
